pipe_sequencer: RTL and testbench



---
 rtl/pipe_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_pipe_sequencer.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/pipe_sequencer.sv
// Sequencing controller for the Flappy-VGA pipe/coin height table: rotation indices,
// scroll offset, coin presence, score counters and the IDLE/RUN/OVER game flow.
// Optional build macro PIPE_SEQ_SPEEDUP_EN: scroll step grows every 8 pipes up to MAX_STEP.
module pipe_sequencer #(
    parameter int PIPE_SPACING = 128,
    parameter int SCROLL_STEP  = 2,
    parameter int MAX_STEP     = 4,
    parameter int COIN_PHASE   = 0
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       Start,
    input  logic       Tick,
    input  logic       Collide,
    input  logic       CoinHit,
    input  logic [2:0] CoinSlot,
    output logic [2:0] I,
    output logic [2:0] IC,
    output logic [9:0] XOffset,
    output logic [4:0] CoinValid,
    output logic [7:0] Score,
    output logic [7:0] CoinCount,
    output logic [1:0] State
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RUN     = 2'b01,
        ST_OVER    = 2'b10,
        ST_ILLEGAL = 2'b11
    } state_t;

    localparam logic [10:0] SPACING_C   = 11'(PIPE_SPACING);
    localparam logic [9:0]  STEP_INIT_C = 10'(SCROLL_STEP);
    localparam logic [9:0]  STEP_MAX_C  = 10'(MAX_STEP);
    localparam logic [2:0]  PHASE_C     = 3'(COIN_PHASE);
`ifdef PIPE_SEQ_SPEEDUP_EN
    localparam logic        SPEEDUP_C   = 1'b1;
`else
    localparam logic        SPEEDUP_C   = 1'b0;
`endif

    // Rotation index advance; any out-of-range value folds back to 0.
    function automatic logic [2:0] inc_mod5(input logic [2:0] v);
        if (v >= 3'd4) begin
            return 3'd0;
        end else begin
            return v + 3'd1;
        end
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        if (v == 8'hFF) begin
            return v;
        end else begin
            return v + 8'd1;
        end
    endfunction

    state_t      state_r, state_s;
    logic [2:0]  i_r, i_s, ic_r, ic_s;
    logic [9:0]  xoff_r, xoff_s;
    logic [4:0]  cv_r, cv_s;
    logic [7:0]  score_r, score_s, cc_r, cc_s;
    logic [9:0]  step_r, step_s;

    logic [10:0] sum_s;
    logic [4:0]  mask_s;
    logic        coin_ok_s;
    logic [4:0]  cv_work_s;
    logic [7:0]  score_inc_s;

    // Slots >= 5 shift the mask out entirely, so they can never clear a bit.
    assign sum_s       = {1'b0, xoff_r} + {1'b0, step_r};
    assign mask_s      = 5'b00001 << CoinSlot;
    assign coin_ok_s   = CoinHit && ((cv_r & mask_s) != 5'b00000);
    assign score_inc_s = sat_inc8(score_r);

    // Next-state and next-register computation for the game-flow FSM.
    always_comb begin
        state_s   = state_r;
        i_s       = i_r;
        ic_s      = ic_r;
        xoff_s    = xoff_r;
        cv_s      = cv_r;
        score_s   = score_r;
        cc_s      = cc_r;
        step_s    = step_r;
        cv_work_s = cv_r;

        case (state_r)
            ST_IDLE: begin
                if (Start) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (Collide) begin
                    state_s = ST_OVER;
                end else begin
                    // Coin clear uses pre-rotation slot numbering, then rotation applies.
                    if (coin_ok_s) begin
                        cv_work_s = cv_r & ~mask_s;
                        cc_s      = sat_inc8(cc_r);
                    end else begin
                        cv_work_s = cv_r;
                    end
                    cv_s = cv_work_s;
                    if (Tick) begin
                        if (sum_s < SPACING_C) begin
                            xoff_s = sum_s[9:0];
                        end else begin
                            xoff_s  = 10'(sum_s - SPACING_C);
                            i_s     = inc_mod5(i_r);
                            ic_s    = inc_mod5(ic_r);
                            cv_s    = {1'b1, cv_work_s[4:1]};
                            score_s = score_inc_s;
                            if (SPEEDUP_C && (score_r != 8'hFF) && (score_inc_s[2:0] == 3'd0)
                                && (step_r < STEP_MAX_C)) begin
                                step_s = step_r + 10'd1;
                            end else begin
                                step_s = step_r;
                            end
                        end
                    end else begin
                        xoff_s = xoff_r;
                    end
                end
            end
            ST_OVER: begin
                if (Start) begin
                    state_s = ST_IDLE;
                    i_s     = 3'd0;
                    ic_s    = PHASE_C;
                    xoff_s  = 10'd0;
                    cv_s    = 5'b11111;
                    score_s = 8'd0;
                    cc_s    = 8'd0;
                    step_s  = STEP_INIT_C;
                end else begin
                    state_s = ST_OVER;
                end
            end
            ST_ILLEGAL: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r <= ST_IDLE;
            i_r     <= 3'd0;
            ic_r    <= PHASE_C;
            xoff_r  <= 10'd0;
            cv_r    <= 5'b11111;
            score_r <= 8'd0;
            cc_r    <= 8'd0;
            step_r  <= STEP_INIT_C;
        end else begin
            state_r <= state_s;
            i_r     <= i_s;
            ic_r    <= ic_s;
            xoff_r  <= xoff_s;
            cv_r    <= cv_s;
            score_r <= score_s;
            cc_r    <= cc_s;
            step_r  <= step_s;
        end
    end

    assign I         = i_r;
    assign IC        = ic_r;
    assign XOffset   = xoff_r;
    assign CoinValid = cv_r;
    assign Score     = score_r;
    assign CoinCount = cc_r;
    assign State     = state_r;

endmodule

// File: tb/tb_pipe_sequencer.sv
// Directed self-checking bench for pipe_sequencer (default build, COIN_PHASE=0).
module tb_pipe_sequencer;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       Start, Tick, Collide, CoinHit;
    logic [2:0] CoinSlot;
    logic [2:0] I, IC;
    logic [9:0] XOffset;
    logic [4:0] CoinValid;
    logic [7:0] Score, CoinCount;
    logic [1:0] State;

    int n_cmp = 0;
    int n_err = 0;

    pipe_sequencer dut (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .Start    (Start),
        .Tick     (Tick),
        .Collide  (Collide),
        .CoinHit  (CoinHit),
        .CoinSlot (CoinSlot),
        .I        (I),
        .IC       (IC),
        .XOffset  (XOffset),
        .CoinValid(CoinValid),
        .Score    (Score),
        .CoinCount(CoinCount),
        .State    (State)
    );

    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock with the given pulses; returns #1 after the edge, pulses cleared.
    task automatic cyc(input logic st, input logic tk, input logic co,
                       input logic ch, input logic [2:0] sl);
        @(negedge Clk);
        Start = st; Tick = tk; Collide = co; CoinHit = ch; CoinSlot = sl;
        @(posedge Clk);
        #1;
        Start = 1'b0; Tick = 1'b0; Collide = 1'b0; CoinHit = 1'b0; CoinSlot = 3'd0;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_state"}, State, 2'b00);
        check_eq({tag, "_i"}, I, 3'd0);
        check_eq({tag, "_ic"}, IC, 3'd0);
        check_eq({tag, "_xoff"}, XOffset, 10'd0);
        check_eq({tag, "_cv"}, CoinValid, 5'b11111);
        check_eq({tag, "_score"}, Score, 8'd0);
        check_eq({tag, "_cc"}, CoinCount, 8'd0);
    endtask

    initial begin
        logic [2:0] i_exp [5];
        i_exp[0] = 3'd1; i_exp[1] = 3'd2; i_exp[2] = 3'd3; i_exp[3] = 3'd4; i_exp[4] = 3'd0;

        Reset_n = 1'b0;
        Start = 1'b0; Tick = 1'b0; Collide = 1'b0; CoinHit = 1'b0; CoinSlot = 3'd0;
        repeat (3) @(posedge Clk);
        #1;
        check_reset_vals("rst");
        @(negedge Clk);
        Reset_n = 1'b1;

        // IDLE ignores Tick, Collide, CoinHit
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
        check_eq("idle_tick_xoff", XOffset, 10'd0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 3'd0);
        check_eq("idle_collide_state", State, 2'b00);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 3'd0);
        check_eq("idle_coin_cv", CoinValid, 5'b11111);

        cyc(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        check_eq("start_state", State, 2'b01);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        check_eq("run_start_ignored", State, 2'b01);

        for (int k = 1; k < 64; k++) begin
            cyc(1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
            check_eq("scroll_xoff", XOffset, 32'(2 * k));
        end
        check_eq("pre_wrap_i", I, 3'd0);

        // Five wraps: I walks 1,2,3,4,0
        for (int w = 0; w < 5; w++) begin
            if (w == 0) ticks(1); else ticks(64);
            check_eq("wrap_xoff", XOffset, 10'd0);
            check_eq("wrap_i", I, i_exp[w]);
            check_eq("wrap_ic", IC, i_exp[w]);
            check_eq("wrap_score", Score, 32'(w + 1));
            check_eq("wrap_cv", CoinValid, 5'b11111);
        end

        cyc(1'b0, 1'b0, 1'b0, 1'b1, 3'd2);
        check_eq("coin2_cv", CoinValid, 5'b11011);
        check_eq("coin2_cc", CoinCount, 8'd1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 3'd2);
        check_eq("coin2_again_cv", CoinValid, 5'b11011);
        check_eq("coin2_again_cc", CoinCount, 8'd1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 3'd6);
        check_eq("coin6_cv", CoinValid, 5'b11011);
        check_eq("coin6_cc", CoinCount, 8'd1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 3'd5);
        check_eq("coin5_cc", CoinCount, 8'd1);

        // Coin in slot 3 on the wrapping tick: clear 11011->10011, then rotate -> 11001
        ticks(63);
        check_eq("prewrap2_xoff", XOffset, 10'd126);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 3'd3);
        check_eq("wrapcoin_cv", CoinValid, 5'b11001);
        check_eq("wrapcoin_cc", CoinCount, 8'd2);
        check_eq("wrapcoin_i", I, 3'd1);
        check_eq("wrapcoin_score", Score, 8'd6);

        // Collide beats Tick and CoinHit
        ticks(3);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 3'd0);
        check_eq("over_state", State, 2'b10);
        check_eq("over_xoff", XOffset, 10'd6);
        check_eq("over_i", I, 3'd1);
        check_eq("over_score", Score, 8'd6);
        check_eq("over_cv", CoinValid, 5'b11001);
        check_eq("over_cc", CoinCount, 8'd2);
        ticks(2);
        check_eq("over_tick_xoff", XOffset, 10'd6);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        check_reset_vals("restart");

        // Reset mid-RUN takes effect before the next edge
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        ticks(7 * 64 + 5);
        check_eq("mid_i", I, 3'd2);
        check_eq("mid_score", Score, 8'd7);
        check_eq("mid_xoff", XOffset, 10'd10);
        #2;
        Reset_n = 1'b0;
        #1;
        check_reset_vals("async_rst");
        @(negedge Clk);
        Reset_n = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
        check_eq("post_rst_xoff", XOffset, 10'd2);
        check_eq("post_rst_state", State, 2'b01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
